// File: rtl/prng_pkg.sv
// Shared FSM state type, default sizes and counter-width helpers for the PRNG seed loader.
package prng_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PRST = 2'd1,
    LOAD = 2'd2,
    WARM = 2'd3
  } state_e;

  localparam int DEF_SIZE_FEED     = 32;
  localparam int DEF_SEED_BITS     = 128;
  localparam int DEF_WARMUP_CYCLES = 256;
  localparam int DEF_RESEED_PERIOD = 65535;

  function automatic int nwords(input int seed_bits, input int size_feed);
    return seed_bits / size_feed;
  endfunction

  // A 1-bit floor keeps degenerate counts (n <= 1) from producing zero-width vectors.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/prng_warmup_cnt.sv
// Loadable down-counter: load has priority, decrements only while enabled, and done pulses on the
// enabled cycle that takes the count from 1 to 0. A zero count stays idle.
module prng_warmup_cnt #(
  parameter int WIDTH = 9
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             en_i,
  output logic             done_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  assign done_o = en_i && (cnt_q == WIDTH'(1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/prng_seed_loader.sv
// Seeds the 128-bit LFSR unit word by word, forces a warm-up, then gates core run requests.
// Defining PRNG_AUTO_RESEED_EN forces a reseed after RESEED_PERIOD granted run cycles.
module prng_seed_loader
  import prng_pkg::*;
#(
  parameter int SIZE_FEED     = DEF_SIZE_FEED,
  parameter int SEED_BITS     = DEF_SEED_BITS,
  parameter int WARMUP_CYCLES = DEF_WARMUP_CYCLES,
  parameter int RESEED_PERIOD = DEF_RESEED_PERIOD
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_seed,
  input  logic [SIZE_FEED-1:0] seed_data,
  input  logic                 seed_valid,
  output logic                 seed_ready,
  input  logic                 core_pre_enable_run,
  output logic                 prng_pre_rst,
  output logic                 prng_feed,
  output logic [SIZE_FEED-1:0] prng_feed_data,
  output logic                 prng_pre_enable_run,
  output logic                 busy,
  output logic                 seeded,
  output logic                 reseed_req
);

  localparam int NWORDS = nwords(SEED_BITS, SIZE_FEED);
  localparam int WORD_W = cnt_width(NWORDS);
  localparam int WARM_W = cnt_width(WARMUP_CYCLES + 1);
  localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(NWORDS - 1);

  if ((SEED_BITS % SIZE_FEED) != 0 || WARMUP_CYCLES < 1 || RESEED_PERIOD < 1) begin : g_bad_cfg
    $error("prng_seed_loader: illegal parameter combination");
  end

  state_e              state_q, state_d;
  logic                seeded_q, seeded_d;
  logic [WORD_W-1:0]   word_cnt_q, word_cnt_d;
  logic                feed_q, feed_d;
  logic [SIZE_FEED-1:0] feed_dat_q, feed_dat_d;
  logic                warm_load, warm_en, warm_done;
  logic                idle_grant, reseed_done;

  // The last word's feed pulse lands in the first WARM cycle; holding the run enable off for that
  // cycle keeps feed and run mutually exclusive and costs the one extra cycle of seeding latency.
  assign warm_en    = (state_q == WARM) && !feed_q;
  assign idle_grant = (state_q == IDLE) && seeded_q && core_pre_enable_run;

  assign prng_pre_enable_run = idle_grant || warm_en;
  assign prng_pre_rst        = (state_q == PRST);
  assign seed_ready          = (state_q == LOAD);
  assign busy                = (state_q != IDLE);
  assign seeded              = seeded_q;
  assign prng_feed           = feed_q;
  assign prng_feed_data      = feed_dat_q;

  always_comb begin
    state_d    = state_q;
    seeded_d   = seeded_q;
    word_cnt_d = word_cnt_q;
    feed_d     = 1'b0;
    feed_dat_d = '0;
    warm_load  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_seed) begin
          seeded_d   = 1'b0;
          word_cnt_d = '0;
          state_d    = PRST;
        end else if (reseed_done) begin
          seeded_d = 1'b0;
        end
      end
      PRST: state_d = LOAD;
      LOAD: begin
        if (seed_valid) begin
          feed_d     = 1'b1;
          feed_dat_d = seed_data;
          if (word_cnt_q == LAST_WORD) begin
            word_cnt_d = '0;
            warm_load  = 1'b1;
            state_d    = WARM;
          end else begin
            word_cnt_d = word_cnt_q + 1'b1;
          end
        end
      end
      WARM: begin
        if (warm_done) begin
          seeded_d = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  prng_warmup_cnt #(.WIDTH(WARM_W)) u_warm_cnt (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .load_i     (warm_load),
    .load_val_i (WARM_W'(WARMUP_CYCLES)),
    .en_i       (warm_en),
    .done_o     (warm_done)
  );

`ifdef PRNG_AUTO_RESEED_EN
  localparam int RUN_W = cnt_width(RESEED_PERIOD + 1);

  logic seed_start;
  logic reseed_req_q, reseed_req_d;

  assign seed_start = (state_q == IDLE) && start_seed;

  prng_warmup_cnt #(.WIDTH(RUN_W)) u_run_cnt (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .load_i     (seed_start),
    .load_val_i (RUN_W'(RESEED_PERIOD)),
    .en_i       (idle_grant),
    .done_o     (reseed_done)
  );

  always_comb begin
    reseed_req_d = reseed_req_q;
    if (seed_start) begin
      reseed_req_d = 1'b0;
    end else if (reseed_done) begin
      reseed_req_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reseed_req_q <= 1'b0;
    end else begin
      reseed_req_q <= reseed_req_d;
    end
  end

  assign reseed_req = reseed_req_q;
`else
  assign reseed_done = 1'b0;
  assign reseed_req  = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      seeded_q   <= 1'b0;
      word_cnt_q <= '0;
      feed_q     <= 1'b0;
      feed_dat_q <= '0;
    end else begin
      state_q    <= state_d;
      seeded_q   <= seeded_d;
      word_cnt_q <= word_cnt_d;
      feed_q     <= feed_d;
      feed_dat_q <= feed_dat_d;
    end
  end

endmodule

// File: tb/tb_prng_seed_loader.sv
// Directed bench for prng_seed_loader: inputs driven and outputs sampled on the falling edge.
module tb_prng_seed_loader;

  localparam int SF = 32;
`ifdef PRNG_AUTO_RESEED_EN
  localparam int RP = 8;
`else
  localparam int RP = 65535;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start_seed = 1'b0;
  logic          seed_valid = 1'b0;
  logic          core_run = 1'b0;
  logic [SF-1:0] seed_data = '0;
  logic          seed_ready, prng_pre_rst, prng_feed, prng_pre_enable_run;
  logic          busy, seeded, reseed_req;
  logic [SF-1:0] prng_feed_data;
  logic [SF-1:0] words [4];
  int            n_vec = 0;
  int            n_bad = 0;

  always #5 clk = ~clk;

  prng_seed_loader #(
    .SIZE_FEED(SF), .SEED_BITS(128), .WARMUP_CYCLES(256), .RESEED_PERIOD(RP)
  ) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .start_seed          (start_seed),
    .seed_data           (seed_data),
    .seed_valid          (seed_valid),
    .seed_ready          (seed_ready),
    .core_pre_enable_run (core_run),
    .prng_pre_rst        (prng_pre_rst),
    .prng_feed           (prng_feed),
    .prng_feed_data      (prng_feed_data),
    .prng_pre_enable_run (prng_pre_enable_run),
    .busy                (busy),
    .seeded              (seeded),
    .reseed_req          (reseed_req)
  );

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_vec++; if (seeded !== 1'b0) begin n_bad++; $display("FAIL reset_seeded got %b want 0", seeded); end
    n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
    n_vec++; if (seed_ready !== 1'b0) begin n_bad++; $display("FAIL reset_seed_ready got %b want 0", seed_ready); end
    n_vec++; if (prng_pre_rst !== 1'b0) begin n_bad++; $display("FAIL reset_pre_rst got %b want 0", prng_pre_rst); end
    n_vec++; if (prng_feed !== 1'b0) begin n_bad++; $display("FAIL reset_feed got %b want 0", prng_feed); end
    n_vec++; if (prng_feed_data !== '0) begin n_bad++; $display("FAIL reset_feed_data got %h want 0", prng_feed_data); end
    n_vec++; if (prng_pre_enable_run !== 1'b0) begin n_bad++; $display("FAIL reset_run got %b want 0", prng_pre_enable_run); end
    n_vec++; if (reseed_req !== 1'b0) begin n_bad++; $display("FAIL reset_reseed_req got %b want 0", reseed_req); end
    rst_n = 1'b1;
  endtask

  // Cycle k counts falling edges after the one that raised start_seed.
  task automatic test_nominal();
    logic e_prst, e_rdy, e_feed, e_run, e_busy, e_seeded;
    @(negedge clk);
    core_run = 1'b0; start_seed = 1'b1; seed_valid = 1'b1; seed_data = words[0];
    for (int k = 1; k <= 264; k++) begin
      @(negedge clk);
      start_seed = 1'b0;
      e_prst = (k == 1);
      e_rdy = (k >= 2 && k <= 5);
      e_feed = (k >= 3 && k <= 6);
      e_run = (k >= 7 && k <= 262);
      e_busy = (k <= 262);
      e_seeded = (k >= 263);
      n_vec++; if (prng_pre_rst !== e_prst) begin n_bad++; $display("FAIL nom_pre_rst c%0d got %b want %b", k, prng_pre_rst, e_prst); end
      n_vec++; if (seed_ready !== e_rdy) begin n_bad++; $display("FAIL nom_seed_ready c%0d got %b want %b", k, seed_ready, e_rdy); end
      n_vec++; if (prng_feed !== e_feed) begin n_bad++; $display("FAIL nom_feed c%0d got %b want %b", k, prng_feed, e_feed); end
      n_vec++; if (prng_pre_enable_run !== e_run) begin n_bad++; $display("FAIL nom_run c%0d got %b want %b", k, prng_pre_enable_run, e_run); end
      n_vec++; if (busy !== e_busy) begin n_bad++; $display("FAIL nom_busy c%0d got %b want %b", k, busy, e_busy); end
      n_vec++; if (seeded !== e_seeded) begin n_bad++; $display("FAIL nom_seeded c%0d got %b want %b", k, seeded, e_seeded); end
      if (e_feed) begin
        n_vec++;
        if (prng_feed_data !== words[k-3]) begin
          n_bad++; $display("FAIL nom_feed_data c%0d got %h want %h", k, prng_feed_data, words[k-3]);
        end
      end
      if (k >= 2 && k <= 5) seed_data = words[k-2];
      if (k == 6) seed_valid = 1'b0;
    end
  endtask

  task automatic test_stalled();
    logic [6:0] pat = 7'b1011001;
    logic       ef [16];
    int         hs = 0;
    int         pulses = 0;
    for (int i = 0; i < 16; i++) ef[i] = 1'b0;
    @(negedge clk);
    start_seed = 1'b1; seed_valid = 1'b0;
    for (int k = 1; k <= 266; k++) begin
      @(negedge clk);
      start_seed = 1'b0;
      if (k <= 12) begin
        n_vec++; if (prng_feed !== ef[k]) begin n_bad++; $display("FAIL stall_feed c%0d got %b want %b", k, prng_feed, ef[k]); end
        if (prng_feed === 1'b1 && pulses < 4) begin
          n_vec++;
          if (prng_feed_data !== words[pulses]) begin
            n_bad++; $display("FAIL stall_order pulse %0d got %h want %h", pulses, prng_feed_data, words[pulses]);
          end
        end
        if (prng_feed === 1'b1) pulses++;
      end
      if (k == 8) begin n_vec++; if (seed_ready !== 1'b1) begin n_bad++; $display("FAIL stall_ready_c8 got %b want 1", seed_ready); end end
      if (k == 9) begin
        n_vec++; if (seed_ready !== 1'b0) begin n_bad++; $display("FAIL stall_ready_c9 got %b want 0", seed_ready); end
        n_vec++; if (prng_pre_enable_run !== 1'b0) begin n_bad++; $display("FAIL stall_gap_run got %b want 0", prng_pre_enable_run); end
      end
      if (k == 12) begin n_vec++; if (pulses != 4) begin n_bad++; $display("FAIL stall_pulse_count got %0d want 4", pulses); end end
      if (k == 265) begin n_vec++; if (seeded !== 1'b0) begin n_bad++; $display("FAIL stall_seeded_early got %b want 0", seeded); end end
      if (k == 266) begin n_vec++; if (seeded !== 1'b1) begin n_bad++; $display("FAIL stall_seeded got %b want 1", seeded); end end
      if (k >= 2 && k <= 8) begin
        seed_valid = pat[k-2];
        seed_data = words[hs];
        if (pat[k-2]) begin ef[k+1] = 1'b1; hs++; end
      end
      if (k == 9) seed_valid = 1'b0;
    end
  endtask

  task automatic test_gating();
    logic e_run;
    core_run = 1'b1; rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      n_vec++; if (prng_pre_enable_run !== 1'b0) begin n_bad++; $display("FAIL gate_unseeded got %b want 0", prng_pre_enable_run); end
    end
    start_seed = 1'b1; seed_valid = 1'b1; seed_data = words[0];
    for (int k = 1; k <= 266; k++) begin
      @(negedge clk);
      start_seed = 1'b0;
      e_run = (k >= 7);
      n_vec++; if (prng_pre_enable_run !== e_run) begin n_bad++; $display("FAIL gate_run c%0d got %b want %b", k, prng_pre_enable_run, e_run); end
      n_vec++; if (prng_feed === 1'b1 && prng_pre_enable_run === 1'b1) begin n_bad++; $display("FAIL gate_exclusive c%0d got feed=1 run=1 want not both", k); end
      if (k == 6) seed_valid = 1'b0;
    end
    core_run = 1'b0;
    @(negedge clk);
    n_vec++; if (prng_pre_enable_run !== 1'b0) begin n_bad++; $display("FAIL gate_follow_low got %b want 0", prng_pre_enable_run); end
    core_run = 1'b1;
    @(negedge clk);
    n_vec++; if (prng_pre_enable_run !== 1'b1) begin n_bad++; $display("FAIL gate_follow_high got %b want 1", prng_pre_enable_run); end
    core_run = 1'b0;
  endtask

  task automatic test_start_during_warm();
    int prst_seen = 0;
    @(negedge clk);
    start_seed = 1'b1; seed_valid = 1'b1; seed_data = words[0];
    for (int k = 1; k <= 264; k++) begin
      @(negedge clk);
      start_seed = (k == 100);
      if (k >= 2 && prng_pre_rst === 1'b1) prst_seen++;
      if (k == 150) begin n_vec++; if (prng_pre_enable_run !== 1'b1) begin n_bad++; $display("FAIL warm_run got %b want 1", prng_pre_enable_run); end end
      if (k == 262) begin
        n_vec++; if (seeded !== 1'b0) begin n_bad++; $display("FAIL warm_seeded_early got %b want 0", seeded); end
        n_vec++; if (busy !== 1'b1) begin n_bad++; $display("FAIL warm_busy got %b want 1", busy); end
      end
      if (k == 263) begin
        n_vec++; if (seeded !== 1'b1) begin n_bad++; $display("FAIL warm_seeded got %b want 1", seeded); end
        n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL warm_idle got %b want 0", busy); end
      end
      if (k == 6) seed_valid = 1'b0;
    end
    n_vec++; if (prst_seen != 0) begin n_bad++; $display("FAIL warm_restart got %0d pre_rst cycles want 0", prst_seen); end
  endtask

  task automatic test_reset_mid_load();
    int feeds = 0;
    @(negedge clk);
    start_seed = 1'b1; seed_valid = 1'b1; seed_data = words[0];
    @(negedge clk); start_seed = 1'b0;
    @(negedge clk); seed_data = words[0];
    @(negedge clk); seed_data = words[1];
    @(negedge clk);
    n_vec++; if (prng_feed !== 1'b1) begin n_bad++; $display("FAIL rml_pre_feed got %b want 1", prng_feed); end
    rst_n = 1'b0;
    #1;
    n_vec++; if (seeded !== 1'b0) begin n_bad++; $display("FAIL rml_seeded got %b want 0", seeded); end
    n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rml_busy got %b want 0", busy); end
    n_vec++; if (seed_ready !== 1'b0) begin n_bad++; $display("FAIL rml_seed_ready got %b want 0", seed_ready); end
    n_vec++; if (prng_feed !== 1'b0) begin n_bad++; $display("FAIL rml_feed got %b want 0", prng_feed); end
    n_vec++; if (prng_feed_data !== '0) begin n_bad++; $display("FAIL rml_feed_data got %h want 0", prng_feed_data); end
    n_vec++; if (prng_pre_rst !== 1'b0) begin n_bad++; $display("FAIL rml_pre_rst got %b want 0", prng_pre_rst); end
    n_vec++; if (prng_pre_enable_run !== 1'b0) begin n_bad++; $display("FAIL rml_run got %b want 0", prng_pre_enable_run); end
    @(negedge clk);
    rst_n = 1'b1;
    start_seed = 1'b1; seed_data = words[0];
    for (int k = 1; k <= 263; k++) begin
      @(negedge clk);
      start_seed = 1'b0;
      if (prng_feed === 1'b1) feeds++;
      if (k == 262) begin n_vec++; if (seeded !== 1'b0) begin n_bad++; $display("FAIL rml_reseed_early got %b want 0", seeded); end end
      if (k == 263) begin n_vec++; if (seeded !== 1'b1) begin n_bad++; $display("FAIL rml_reseed got %b want 1", seeded); end end
      if (k >= 2 && k <= 5) seed_data = words[k-2];
      if (k == 6) seed_valid = 1'b0;
    end
    n_vec++; if (feeds != 4) begin n_bad++; $display("FAIL rml_feed_count got %0d want 4", feeds); end
  endtask

`ifdef PRNG_AUTO_RESEED_EN
  task automatic test_auto_reseed();
    @(negedge clk);
    core_run = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      if (n < 8) begin
        n_vec++; if (prng_pre_enable_run !== 1'b1) begin n_bad++; $display("FAIL ars_run n%0d got %b want 1", n, prng_pre_enable_run); end
        n_vec++; if (reseed_req !== 1'b0) begin n_bad++; $display("FAIL ars_req_early n%0d got %b want 0", n, reseed_req); end
      end else begin
        n_vec++; if (reseed_req !== 1'b1) begin n_bad++; $display("FAIL ars_req got %b want 1", reseed_req); end
        n_vec++; if (seeded !== 1'b0) begin n_bad++; $display("FAIL ars_seeded got %b want 0", seeded); end
        n_vec++; if (prng_pre_enable_run !== 1'b0) begin n_bad++; $display("FAIL ars_blocked got %b want 0", prng_pre_enable_run); end
      end
    end
    start_seed = 1'b1;
    @(negedge clk);
    start_seed = 1'b0; core_run = 1'b0;
    n_vec++; if (reseed_req !== 1'b0) begin n_bad++; $display("FAIL ars_clear got %b want 0", reseed_req); end
    n_vec++; if (busy !== 1'b1) begin n_bad++; $display("FAIL ars_busy got %b want 1", busy); end
  endtask
`endif

  initial begin
    words[0] = 32'h1111_1111;
    words[1] = 32'h2222_2222;
    words[2] = 32'h3333_3333;
    words[3] = 32'h4444_4444;
    test_reset();
    test_nominal();
    test_stalled();
    test_gating();
    test_start_during_warm();
    test_reset_mid_load();
`ifdef PRNG_AUTO_RESEED_EN
    test_auto_reseed();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/prng_seed_loader.md
Name: prng_seed_loader

Overview:
- Upstream controller for the 128-bit randomness LFSR unit. It drives that unit's pre_rst, feed/feed_data and pre_enable_run inputs.
- Accepts a seed as a valid/ready stream of SIZE_FEED-bit words, then runs a fixed warm-up phase to diffuse the seed.
- Gates core run requests so the masked core never consumes randomness from an unseeded or partially loaded LFSR.

Parameters:
- SIZE_FEED, 32, width of one seed word; must divide SEED_BITS.
- SEED_BITS, 128, total seed bits (LFSR state width).
- WARMUP_CYCLES, 256, LFSR update cycles forced after the last seed word; must be >= 1.
- RESEED_PERIOD, 65535, granted run cycles before reseed is mandatory (used only with the optional feature).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start_seed  in  1  one-cycle request to (re)seed.
- seed_data  in  SIZE_FEED  seed word.
- seed_valid  in  1  seed word valid.
- seed_ready  out  1  seed word accepted when seed_valid & seed_ready.
- core_pre_enable_run  in  1  run request from core control.
- prng_pre_rst  out  1  to LFSR unit pre_rst.
- prng_feed  out  1  to LFSR unit feed.
- prng_feed_data  out  SIZE_FEED  to LFSR unit feed_data.
- prng_pre_enable_run  out  1  to LFSR unit pre_enable_run.
- busy  out  1  seeding or warm-up in progress.
- seeded  out  1  LFSR holds a fully loaded, warmed-up seed.
- reseed_req  out  1  reseed required (optional feature only; tied 0 otherwise).

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, word_cnt=0, warm_cnt=0. All outputs 0: seeded, busy, seed_ready, prng_pre_rst, prng_feed, prng_feed_data, prng_pre_enable_run, reseed_req. Reset mid-load or mid-warm-up aborts the operation and leaves seeded=0.
- NWORDS = SEED_BITS/SIZE_FEED, giving 4 words at the defaults. Counters are sized with $clog2, and a width of at least 1 bit is forced.
- FSM states and transitions:
  - IDLE: on start_seed, seeded<=0 and go to PRST. While seeded=1, prng_pre_enable_run = core_pre_enable_run (combinational). Otherwise prng_pre_enable_run=0.
  - PRST: prng_pre_rst=1 for exactly one cycle, then go to LOAD.
  - LOAD: seed_ready=1. Each handshake registers prng_feed<=1 and prng_feed_data<=seed_data for the next cycle only, and increments word_cnt. While seed_valid=0, prng_feed=0 and word_cnt holds. On the NWORDS-th handshake, seed_ready drops in the following cycle and the FSM goes to WARM. The first word lands in the LFSR top word and is shifted down by later words.
  - WARM: prng_pre_enable_run=1 for WARMUP_CYCLES consecutive cycles, counted by warm_cnt. core_pre_enable_run is ignored. On the last cycle: seeded<=1, go to IDLE.
- busy=1 in PRST, LOAD and WARM.
- start_seed is ignored when busy=1. A start_seed in IDLE with seeded=1 clears seeded in the same edge.
- prng_feed and prng_pre_enable_run are never both 1 in the same cycle.
- Latency from start_seed to seeded=1, with seed_valid held high: 1 (PRST) + NWORDS + WARMUP_CYCLES + 1 cycles.

Optional Feature:
- Macro: PRNG_AUTO_RESEED_EN.
- Defined:
  - A run counter (width $clog2(RESEED_PERIOD+1)) increments on each cycle with prng_pre_enable_run=1 in IDLE.
  - When the count reaches RESEED_PERIOD: reseed_req<=1, seeded<=0, further core runs blocked.
  - reseed_req and the counter clear on the start_seed handshake into PRST.
- Undefined: no counter; reseed_req tied 0; seeded stays 1 until the next start_seed or reset.

Decomposition:
- Shared package prng_pkg: FSM state enum (IDLE, PRST, LOAD, WARM), NWORDS/counter-width localparams, default SEED_BITS/SIZE_FEED.
- One natural sub-module: prng_warmup_cnt, a loadable down-counter with a done pulse. It is reused by the optional reseed counter.
- Instantiated directly above the LFSR unit. The upstream side connects to the host seed bus.

Test Plan:
- Reset mid-LOAD: assert rst_n=0 after 2 of 4 words -> all outputs 0 immediately (async); later reseed completes normally with seeded=1.
- Nominal seed: start_seed, then words 0x11111111, 0x22222222, 0x33333333, 0x44444444 with valid held -> prng_pre_rst one cycle, then prng_feed on 4 consecutive cycles carrying those words in order. seeded=1 exactly 1+4+256+1 cycles after start_seed.
- Stalled source: seed_valid toggled 1,0,0,1,1,0,1 -> prng_feed pulses only the cycle after each handshake; exactly 4 pulses; word order preserved.
- Gating: core_pre_enable_run=1 throughout -> prng_pre_enable_run=0 before seeding and in PRST/LOAD; 1 for all 256 WARM cycles; follows core_pre_enable_run after seeded.
- start_seed during WARM -> ignored; warm-up finishes and seeded=1 at the unchanged cycle count.
- PRNG_AUTO_RESEED_EN with RESEED_PERIOD=8: 8 granted run cycles -> reseed_req=1, seeded=0, runs blocked; start_seed clears reseed_req in the next cycle.
